serial_deserializer: RTL and testbench

//  Receive end of the MSB-first serial link driven by shift_register.
//  - Samples one bit per qualified clock and assembles N-bit words.
//  - Presents each completed word on a valid/ready output port.
//  - Flags framing errors (early start) and overruns (word lost).
//  - Sits between the serial line and the parallel consumer logic.

---
 rtl/serial_pkg.sv | 11 +
 rtl/serial_deserializer_if.sv | 24 ++
 rtl/serial_deserializer.sv | 106 ++++++++++
 tb/tb_serial_deserializer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types for the serial link blocks (transmit shift_register and this receiver).
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial line in, parallel word out. The word port is valid/ready: a word moves
// on a cycle where out_valid and out_ready are both 1; data_out holds still while out_valid=1 and out_ready=0.
interface serial_deserializer_if #(
    parameter int N = 8
);
    logic         serial_in;
    logic         bit_valid;
    logic         start;
    logic [N-1:0] data_out;
    logic         out_valid;
    logic         out_ready;
    logic         frame_error;
    logic         overrun;

    modport master (
        output serial_in, bit_valid, start, out_ready,
        input  data_out, out_valid, frame_error, overrun
    );

    modport slave (
        input  serial_in, bit_valid, start, out_ready,
        output data_out, out_valid, frame_error, overrun
    );
endinterface

// File: rtl/serial_deserializer.sv
// MSB-first serial receiver: assembles N-bit words and offers them on a valid/ready port,
// flagging mid-word starts (frame_error) and words lost to a stalled consumer (overrun).
module serial_deserializer
    import serial_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic                clock,
    input  logic                reset_n,
    serial_deserializer_if.slave link,
    output rx_state_t           state_dbg
);

    localparam int             CW   = $clog2(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    rx_state_t     state, state_nxt;
    logic [N-1:0]  shreg, shreg_nxt;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic [N-1:0]  shifted;
    logic          word_done;
    logic          resync;

    logic [N-1:0]  data_q;
    logic          valid_q;
    logic          frame_error_q;
    logic          overrun_q;

    assign shifted = {shreg[N-2:0], link.serial_in};

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        word_done   = 1'b0;
        resync      = 1'b0;
        if (link.bit_valid) begin
            case (state)
                IDLE: begin
                    if (link.start) begin
                        shreg_nxt   = shifted;
                        bit_cnt_nxt = CW'(1);
                        state_nxt   = SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_nxt = shifted;
                    if (link.start) begin
                        // Older bits shift out before this word completes, so no clear is needed.
                        resync      = 1'b1;
                        bit_cnt_nxt = CW'(1);
                    end else if (bit_cnt == LAST) begin
                        word_done   = 1'b1;
                        bit_cnt_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            frame_error_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            shreg         <= shreg_nxt;
            bit_cnt       <= bit_cnt_nxt;
            frame_error_q <= resync;
        end
    end

    // A completed word replaces the held one only if the held one is gone or leaving now.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (word_done) begin
                if (!valid_q || link.out_ready) begin
                    data_q  <= shifted;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (link.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign link.data_out    = data_q;
    assign link.out_valid   = valid_q;
    assign link.frame_error = frame_error_q;
    assign link.overrun     = overrun_q;
    assign state_dbg        = state;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer (N=6): directed scenarios then random traffic,
// checked cycle by cycle against a bit-list model of the link.
module tb_serial_deserializer;
  import serial_pkg::*;

  localparam int N = 6;

  logic      clock;
  logic      reset_n;
  rx_state_t state_dbg;

  serial_deserializer_if #(.N(N)) link ();

  serial_deserializer #(.N(N)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .link      (link),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #50 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model: bits of the frame in progress plus the output register contents
  logic         m_bits[$];
  logic         m_in_frame = 1'b0;
  logic [N-1:0] m_dout     = '0;
  logic         m_ov       = 1'b0;
  logic         m_fe       = 1'b0;
  logic         m_or       = 1'b0;
  int unsigned  m_or_count = 0;
  int unsigned  m_fe_count = 0;
  logic [N-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_in_frame = 1'b0;
    m_dout     = '0;
    m_ov       = 1'b0;
    m_fe       = 1'b0;
    m_or       = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".data_out"},    32'(link.data_out),    32'(m_dout));
    chk({where, ".out_valid"},   32'(link.out_valid),   32'(m_ov));
    chk({where, ".frame_error"}, 32'(link.frame_error), 32'(m_fe));
    chk({where, ".overrun"},     32'(link.overrun),     32'(m_or));
    chk({where, ".in_word"},     32'(state_dbg == SHIFT), 32'(m_in_frame));
  endtask

  // driver: one clock cycle with the given inputs, model advanced alongside
  task automatic step(input logic sv, input logic bv, input logic st, input logic rdy);
    logic         done;
    logic [N-1:0] w;
    logic [N-1:0] got;
    done = 1'b0;
    w    = '0;
    if (link.out_valid && rdy) begin
      chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        chk("sb_word", 32'(link.data_out), 32'(got));
      end
    end
    link.serial_in = sv;
    link.bit_valid = bv;
    link.start     = st;
    link.out_ready = rdy;

    m_fe = 1'b0;
    m_or = 1'b0;
    if (bv) begin
      if (st) begin
        if (m_in_frame) begin
          m_fe = 1'b1;
          m_fe_count++;
        end
        m_bits.delete();
        m_bits.push_back(sv);
        m_in_frame = 1'b1;
      end else if (m_in_frame) begin
        m_bits.push_back(sv);
        if (m_bits.size() == N) begin
          foreach (m_bits[i]) w = {w[N-2:0], m_bits[i]};
          done = 1'b1;
          m_bits.delete();
          m_in_frame = 1'b0;
        end
      end
    end
    if (done) begin
      if (!m_ov || rdy) begin
        m_dout = w;
        m_ov   = 1'b1;
        exp_q.push_back(w);
      end else begin
        m_or = 1'b1;
        m_or_count++;
      end
    end else if (rdy) begin
      m_ov = 1'b0;
    end

    @(posedge clock);
    #1;
    check_outputs("cycle");
  endtask

  task automatic send_word(input logic [N-1:0] word, input logic rdy, input bit gapped);
    for (int i = N - 1; i >= 0; i--) begin
      step(word[i], 1'b1, (i == N - 1), rdy);
      if (gapped && i != 0) step(1'b0, 1'b0, 1'b0, rdy);
    end
  endtask

  initial begin
    int unsigned or_before;
    int unsigned fe_before;
    int unsigned valid_run;
    logic [N-1:0] seen[$];

    reset_n        = 1'b0;
    link.serial_in = 1'b0;
    link.bit_valid = 1'b0;
    link.start     = 1'b0;
    link.out_ready = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    check_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // basic word
    send_word(6'b101101, 1'b1, 1'b0);
    chk("basic_word", 32'(link.data_out), 32'(6'b101101));
    chk("basic_valid", 32'(link.out_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic_valid_one_cycle", 32'(link.out_valid), 32'd0);

    // stray bits without a start are ignored, then a gapped word
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    send_word(6'b110010, 1'b1, 1'b1);
    chk("gapped_word", 32'(link.data_out), 32'(6'b110010));
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // resync: three bits, then a fresh start
    fe_before = m_fe_count;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("resync_fe_pulse", 32'(link.frame_error), 32'd1);
    for (int i = 4; i >= 0; i--) step((i == 0), 1'b1, 1'b0, 1'b1);
    chk("resync_word", 32'(link.data_out), 32'(6'b000001));
    chk("resync_fe_once", m_fe_count - fe_before, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // overrun with stalled consumer
    or_before = m_or_count;
    send_word(6'b111000, 1'b0, 1'b0);
    send_word(6'b000111, 1'b0, 1'b0);
    chk("overrun_pulse", 32'(link.overrun), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("overrun_held_word", 32'(link.data_out), 32'(6'b111000));
    chk("overrun_held_valid", 32'(link.out_valid), 32'd1);
    chk("overrun_once", m_or_count - or_before, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // back-to-back words, no gap
    valid_run = 0;
    for (int k = 0; k < 2; k++) begin
      logic [N-1:0] wd;
      wd = (k == 0) ? 6'b010101 : 6'b101010;
      for (int i = N - 1; i >= 0; i--) begin
        step(wd[i], 1'b1, (i == N - 1), 1'b1);
        if (link.out_valid) begin
          valid_run++;
          seen.push_back(link.data_out);
        end
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_valid_cycles", valid_run, 32'd2);
    chk("b2b_first", 32'(seen.size() > 0 ? seen[0] : '1), 32'(6'b010101));
    chk("b2b_second", 32'(seen.size() > 1 ? seen[1] : '1), 32'(6'b101010));

    // async reset mid-word while a word is still held
    send_word(6'b100110, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    #20;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
